// File: rtl/layer_eval_pkg.sv
// Shared types and helpers for the layer evaluator.
// Imported by every layer stage file.
package layer_eval_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int calc_ninbits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/field_alu.sv
// Combinational GF(2^nbits - 1) add/mul with canonical output.
// Mersenne reduction folds the high half back onto the low half.
module field_alu #(
  parameter int nbits = 61
) (
  input  logic [nbits-1:0] a,
  input  logic [nbits-1:0] b,
  input  logic             mul_sel,
  output logic [nbits-1:0] result
);

  localparam logic [nbits-1:0] P = '1;

  logic [nbits:0]         s;
  logic [nbits-1:0]       r_add;
  logic [2*nbits-1:0]     prod;
  logic [nbits:0]         f1;
  logic [nbits-1:0]       f2;
  logic [nbits-1:0]       red;

  always_comb begin
    s     = {1'b0, a} + {1'b0, b};
    r_add = s[nbits-1:0] + (nbits)'(s[nbits]);
    prod  = {{nbits{1'b0}}, a} * {{nbits{1'b0}}, b};
    f1    = {1'b0, prod[nbits-1:0]}
          + {1'b0, prod[2*nbits-1:nbits]};
    f2    = f1[nbits-1:0] + (nbits)'(f1[nbits]);
    red   = mul_sel ? f2 : r_add;
    // p itself is the second encoding of zero
    result = (red == P) ? '0 : red;
  end

endmodule

// File: rtl/layer_eval_seq.sv
// Sequential one-gate-per-cycle evaluator for one circuit layer.
// Latches the previous layer, fills v_out gate by gate.
module layer_eval_seq
  import layer_eval_pkg::*;
#(
  parameter int ngates  = 8,
  parameter int ninputs = 8,
  parameter int nbits   = 61,
  parameter logic [ngates-1:0] gates_mul = '0,
  parameter int ninbits = calc_ninbits(ninputs),
  parameter logic [ngates*ninbits-1:0] gates_in0 = '0,
  parameter logic [ngates*ninbits-1:0] gates_in1 = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [ninputs*nbits-1:0]  v_in,
  output logic [ngates*nbits-1:0]   v_out,
  output logic                      ready,
  output logic                      done
);

  localparam int cw = (ngates > 1) ? $clog2(ngates) : 1;

  // Illegal configurations instantiate a module that does not exist
  if (ngates < 1) begin : g_bad_ngates
    layer_eval_bad_ngates u_bad ();
  end

  for (genvar g = 0; g < ngates; g++) begin : g_chk
    if (int'(gates_in0[g*ninbits +: ninbits]) >= ninputs ||
        int'(gates_in1[g*ninbits +: ninbits]) >= ninputs)
    begin : g_bad
      layer_eval_bad_gate_index u_bad ();
    end
  end

  state_t            state;
  logic [cw-1:0]     cnt;
  logic [nbits-1:0]  vin_lat [ninputs];
  logic [ninbits-1:0] sel0;
  logic [ninbits-1:0] sel1;
  logic              op_mul;
  logic [nbits-1:0]  opa;
  logic [nbits-1:0]  opb;
  logic [nbits-1:0]  alu_r;

  always_comb begin
    sel0   = '0;
    sel1   = '0;
    op_mul = 1'b0;
    for (int g = 0; g < ngates; g++) begin
      if (cnt == cw'(g)) begin
        sel0   = gates_in0[g*ninbits +: ninbits];
        sel1   = gates_in1[g*ninbits +: ninbits];
        op_mul = gates_mul[g];
      end
    end
  end

  always_comb begin
    opa = '0;
    opb = '0;
    for (int i = 0; i < ninputs; i++) begin
      if (sel0 == ninbits'(i)) opa = vin_lat[i];
      if (sel1 == ninbits'(i)) opb = vin_lat[i];
    end
  end

  field_alu #(.nbits(nbits)) u_alu (
    .a       (opa),
    .b       (opb),
    .mul_sel (op_mul),
    .result  (alu_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      v_out <= '0;
      cnt   <= '0;
      for (int i = 0; i < ninputs; i++)
        vin_lat[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            for (int i = 0; i < ninputs; i++)
              vin_lat[i] <= v_in[i*nbits +: nbits];
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
          end
        end
        RUN: begin
          for (int g = 0; g < ngates; g++)
            if (cnt == cw'(g))
              v_out[g*nbits +: nbits] <= alu_r;
          if (cnt == cw'(ngates - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
